// File: rtl/kr580_pkg.sv
// Shared definitions for the KR580 interrupt controller: register offsets,
// default I/O base and small bit-vector helpers.
package kr580_pkg;

  localparam logic [1:0] PIC_IRR = 2'd0;
  localparam logic [1:0] PIC_IMR = 2'd1;
  localparam logic [1:0] PIC_VEC = 2'd2;
  localparam logic [1:0] PIC_ISR = 2'd3;

  localparam logic [7:0] PIC_BASE = 8'hF8;

  // One-hot decode of a 3-bit source index.
  function automatic logic [7:0] onehot8(input logic [2:0] n);
    onehot8 = 8'h01 << n;
  endfunction

  // Sources allowed to interrupt while source k is in service: indices below k.
  // With nothing in service every source is allowed.
  function automatic logic [7:0] prio_mask8(input logic v, input logic [2:0] k);
    if (v) begin
      prio_mask8 = (8'h01 << k) - 8'h01;
    end else begin
      prio_mask8 = 8'hFF;
    end
  endfunction

endpackage

// File: rtl/kr580_prienc8.sv
// Combinational 8-input priority encoder; the lowest set index wins.
module kr580_prienc8 (
  input  logic [7:0] req,
  output logic       valid,
  output logic [2:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = req[i] ? 3'(i) : idx;
    end
  end

endmodule

// File: rtl/kr580_pic.sv
// Eight-input priority interrupt controller on the KR580 port bus.
// Edge-latched requests, mask, fixed priority (bit 0 highest), software
// vector read, ACK and EOI. No INTA cycle.
module kr580_pic
  import kr580_pkg::*;
#(
  parameter logic [7:0] BASE = PIC_BASE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] irq,
  input  logic [7:0] pa,
  input  logic [7:0] po,
  input  logic       pw,
  output logic [7:0] pi,
  output logic       intr
);

  logic [7:0] sync1_r, sync2_r, hist_r;
  logic [7:0] irr_r, imr_r, isr_r;
  logic       intr_r;

  logic       hit_s;
  logic [1:0] off_s;
  logic       wr_irr_s, wr_imr_s, wr_vec_s, wr_isr_s;
  logic [7:0] edge_s, pend_s, prio_mask_s, vec_src_s;
  logic [7:0] irr_clr_s, isr_nxt_s, vec_s;
  logic       pend_v, isr_v, vec_v, req_s;
  logic [2:0] pend_n, isr_n, vec_n;

  assign hit_s    = (pa[7:2] == BASE[7:2]);
  assign off_s    = pa[1:0];
  assign wr_irr_s = pw & hit_s & (off_s == PIC_IRR);
  assign wr_imr_s = pw & hit_s & (off_s == PIC_IMR);
  assign wr_vec_s = pw & hit_s & (off_s == PIC_VEC);
  assign wr_isr_s = pw & hit_s & (off_s == PIC_ISR);

  // Rising edge seen at the synchronizer output.
  assign edge_s = sync2_r & ~hist_r;
  assign pend_s = irr_r & ~imr_r;

  kr580_prienc8 u_pend (.req(pend_s), .valid(pend_v), .idx(pend_n));
  kr580_prienc8 u_isr  (.req(isr_r),  .valid(isr_v),  .idx(isr_n));

  assign prio_mask_s = prio_mask8(isr_v, isr_n);
  assign vec_src_s   = pend_s & prio_mask_s;

  kr580_prienc8 u_vec  (.req(vec_src_s), .valid(vec_v), .idx(vec_n));

  // The best unmasked pending source must outrank the best in-service one.
  assign req_s = pend_v & (~isr_v | (pend_n < isr_n));
  assign vec_s = vec_v ? {1'b1, 4'b0000, vec_n} : 8'h00;

  // IRR bits cleared by software this cycle (W1C or ACK).
  always_comb begin
    irr_clr_s = 8'h00;
    if (wr_irr_s) begin
      irr_clr_s = po;
    end else if (wr_vec_s) begin
      irr_clr_s = onehot8(po[2:0]);
    end else begin
      irr_clr_s = 8'h00;
    end
  end

  // ISR next state: ACK sets a bit, EOI retires the highest-priority bit.
  always_comb begin
    isr_nxt_s = isr_r;
    if (wr_vec_s) begin
      isr_nxt_s = isr_r | onehot8(po[2:0]);
    end else if (wr_isr_s && isr_v) begin
      isr_nxt_s = isr_r & ~onehot8(isr_n);
    end else begin
      isr_nxt_s = isr_r;
    end
  end

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= 8'h00;
      sync2_r <= 8'h00;
      hist_r  <= 8'h00;
    end else begin
      sync1_r <= irq;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
    end
  end

  // Software-visible registers; a new edge wins over a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irr_r <= 8'h00;
      imr_r <= 8'hFF;
      isr_r <= 8'h00;
    end else begin
      irr_r <= (irr_r & ~irr_clr_s) | edge_s;
      imr_r <= wr_imr_s ? po : imr_r;
      isr_r <= isr_nxt_s;
    end
  end

  // Registered interrupt request to the CPU.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      intr_r <= 1'b0;
    end else begin
      intr_r <= req_s;
    end
  end

  assign intr = intr_r;

  // Port read mux; undecoded addresses read as zero.
  always_comb begin
    pi = 8'h00;
    if (hit_s) begin
      case (off_s)
        PIC_IRR: pi = irr_r;
        PIC_IMR: pi = imr_r;
        PIC_VEC: pi = vec_s;
        PIC_ISR: pi = isr_r;
        default: pi = 8'h00;
      endcase
    end else begin
      pi = 8'h00;
    end
  end

endmodule

// File: tb/tb_kr580_pic.sv
// Directed self-checking bench for kr580_pic.
`timescale 1ns/1ps
module tb_kr580_pic;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] irq, pa, po;
  logic       pw;
  logic [7:0] pi;
  logic       intr;

  logic [7:0] pa2, po2;
  logic       pw2;
  logic [7:0] pi2;
  logic       intr2;

  int n_pass = 0;
  int n_total = 0;

  always #10 clock = ~clock;

  kr580_pic #(.BASE(8'hF8)) dut (
    .clock(clock), .reset(reset), .irq(irq), .pa(pa), .po(po), .pw(pw),
    .pi(pi), .intr(intr)
  );

  kr580_pic #(.BASE(8'h10)) dut2 (
    .clock(clock), .reset(reset), .irq(8'h00), .pa(pa2), .po(po2), .pw(pw2),
    .pi(pi2), .intr(intr2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    pa = a;
    #1;
    chk(tag, pi, exp);
  endtask

  task automatic chk_rd2(input string tag, input logic [7:0] a, input logic [7:0] exp);
    pa2 = a;
    #1;
    chk(tag, pi2, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    pa = a; po = d; pw = 1'b1;
    @(negedge clock);
    pw = 1'b0;
  endtask

  task automatic wr2(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    pa2 = a; po2 = d; pw2 = 1'b1;
    @(negedge clock);
    pw2 = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; irq = 8'h00; pa = 8'h00; po = 8'h00; pw = 1'b0;
    pa2 = 8'h00; po2 = 8'h00; pw2 = 1'b0;
    wait_neg(2);
    reset = 1'b0;

    // Build some state, then reset asynchronously mid-cycle
    wr(8'hF9, 8'h00);
    wr(8'hFA, 8'h03);
    chk_rd("pre_reset_isr", 8'hFB, 8'h08);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("rst_intr", {7'd0, intr}, 8'h00);
    chk_rd("rst_imr", 8'hF9, 8'hFF);
    chk_rd("rst_irr", 8'hF8, 8'h00);
    chk_rd("rst_isr", 8'hFB, 8'h00);
    chk_rd("rst_vec", 8'hFA, 8'h00);
    wait_neg(2);
    reset = 1'b0;

    // Basic request on source 2
    wr(8'hF9, 8'hFB);
    irq[2] = 1'b1;
    wait_neg(3);
    chk_rd("basic_irr_3clk", 8'hF8, 8'h04);
    chk("basic_intr_not_yet", {7'd0, intr}, 8'h00);
    wait_neg(1);
    chk("basic_intr", {7'd0, intr}, 8'h01);
    irq[2] = 1'b0;
    chk_rd("basic_vec", 8'hFA, 8'h82);
    wr(8'hFA, 8'h02);
    chk_rd("ack_irr", 8'hF8, 8'h00);
    chk_rd("ack_isr", 8'hFB, 8'h04);
    chk("ack_intr_same_cycle", {7'd0, intr}, 8'h01);
    wait_neg(1);
    chk("ack_intr_next", {7'd0, intr}, 8'h00);
    wr(8'hFB, 8'h00);
    chk_rd("eoi_isr", 8'hFB, 8'h00);
    wait_neg(4);
    chk_rd("fall_ignored_irr", 8'hF8, 8'h00);

    // Priority and nesting
    wr(8'hF9, 8'h00);
    wr(8'hFA, 8'h03);
    chk_rd("nest_isr3", 8'hFB, 8'h08);
    irq[5] = 1'b1;
    wait_neg(4);
    irq[5] = 1'b0;
    chk_rd("nest_irr5", 8'hF8, 8'h20);
    chk("nest_intr5_blocked", {7'd0, intr}, 8'h00);
    chk_rd("nest_vec5_blocked", 8'hFA, 8'h00);
    irq[1] = 1'b1;
    wait_neg(4);
    irq[1] = 1'b0;
    chk_rd("nest_irr15", 8'hF8, 8'h22);
    chk("nest_intr1", {7'd0, intr}, 8'h01);
    chk_rd("nest_vec1", 8'hFA, 8'h81);
    wr(8'hFA, 8'h01);
    chk_rd("nest_ack1_isr", 8'hFB, 8'h0A);
    chk_rd("nest_ack1_irr", 8'hF8, 8'h20);
    wr(8'hFB, 8'h00);
    chk_rd("nest_eoi1_isr", 8'hFB, 8'h08);
    wait_neg(1);
    chk("nest_intr_low", {7'd0, intr}, 8'h00);
    wr(8'hFB, 8'h00);
    chk_rd("nest_eoi3_isr", 8'hFB, 8'h00);
    chk("nest_intr_before_edge", {7'd0, intr}, 8'h00);
    wait_neg(1);
    chk("nest_intr5", {7'd0, intr}, 8'h01);
    chk_rd("nest_vec5", 8'hFA, 8'h85);
    wr(8'hFA, 8'h05);
    wr(8'hFB, 8'h00);
    wr(8'hFB, 8'h00);
    chk_rd("eoi_empty_isr", 8'hFB, 8'h00);

    // Masking and W1C
    wr(8'hF9, 8'hFF);
    irq[4] = 1'b1; irq[5] = 1'b1;
    wait_neg(4);
    irq[4] = 1'b0; irq[5] = 1'b0;
    chk_rd("mask_irr", 8'hF8, 8'h30);
    chk("mask_intr", {7'd0, intr}, 8'h00);
    chk_rd("mask_vec", 8'hFA, 8'h00);
    wr(8'hF9, 8'hEF);
    chk("unmask_intr_same", {7'd0, intr}, 8'h00);
    wait_neg(1);
    chk("unmask_intr", {7'd0, intr}, 8'h01);
    chk_rd("unmask_vec", 8'hFA, 8'h84);
    wr(8'hF8, 8'h10);
    chk_rd("w1c_irr", 8'hF8, 8'h20);
    wait_neg(1);
    chk("w1c_intr", {7'd0, intr}, 8'h00);
    chk_rd("w1c_vec", 8'hFA, 8'h00);
    wr(8'hF8, 8'hFF);
    chk_rd("w1c_all", 8'hF8, 8'h00);

    // Set wins: W1C of bit 0 lands on the edge that sets IRR[0]
    irq[0] = 1'b1;
    wait_neg(1);
    wr(8'hF8, 8'h01);
    chk_rd("setwins_irr", 8'hF8, 8'h01);
    irq[0] = 1'b0;
    wr(8'hF8, 8'h01);
    chk_rd("setwins_cleared", 8'hF8, 8'h00);

    // Decode: writes outside BASE..BASE+3 change nothing
    wr(8'hF5, 8'h00);
    wr(8'hF6, 8'h03);
    wr(8'hF7, 8'h00);
    chk_rd("dec_imr", 8'hF9, 8'hEF);
    chk_rd("dec_isr", 8'hFB, 8'h00);
    chk_rd("dec_f4", 8'hF4, 8'h00);
    chk_rd("dec_f5", 8'hF5, 8'h00);
    chk_rd("dec_fc", 8'hFC, 8'h00);

    // Second instance at BASE=8'h10
    chk_rd2("b10_imr", 8'h11, 8'hFF);
    chk_rd2("b10_f9", 8'hF9, 8'h00);
    chk_rd2("b10_14", 8'h14, 8'h00);
    chk_rd2("b10_0f", 8'h0F, 8'h00);
    wr2(8'h15, 8'h00);
    chk_rd2("b10_imr_kept", 8'h11, 8'hFF);
    wr2(8'h11, 8'h3C);
    chk_rd2("b10_imr_wr", 8'h11, 8'h3C);
    chk("b10_intr", {7'd0, intr2}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
